// File: rtl/fsm_receptor_pkg.sv
// Shared types and handshake codes for the send/ack receptor.
// Imported by the FSM top and its FIFO.
package receptor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;
  localparam logic [1:0] ACK_IDLE  = 2'b00;
  localparam logic [1:0] ACK_OK    = 2'b01;

endpackage

// File: rtl/fsm_receptor_if.sv
// Bundle of the send/ack handshake and the read/status port of one receptor.
// master = processor/consumer side, slave = fsm_receptor.
interface fsm_receptor_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        send;
  logic [DATA_W-1:0] dado;
  logic [1:0]        ack;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  rx_total;
  logic              err;

  modport master (
    output send, dado, rd_en,
    input  ack, rd_data, count, empty, full, rx_total, err
  );

  modport slave (
    input  send, dado, rd_en,
    output ack, rd_data, count, empty, full, rx_total, err
  );
endinterface

// File: rtl/fsm_receptor_rx_fifo.sv
// Word buffer for the receptor: DEPTH-entry circular FIFO with registered read data.
// Writes are dropped when full, reads are ignored when empty; no write-to-read bypass.
module rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer arithmetic wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
endmodule

// File: rtl/fsm_receptor.sv
// Four-phase send/ack receiver: accepts one word per handshake into rx_fifo,
// counts accepted words and latches a sticky error on illegal send codes.
module fsm_receptor
  import receptor_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  fsm_receptor_if.slave  bus
);
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] rx_total_q, rx_total_d;
  logic             err_q, err_d;
  logic             wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_total_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_total_q <= rx_total_d;
      err_q      <= err_d;
    end
  end

  // Illegal codes never match SEND_REQ/SEND_IDLE, so they leave the state alone.
  always_comb begin
    state_d    = state_q;
    rx_total_d = rx_total_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    if (bus.send[1]) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.send == SEND_REQ && !bus.full) begin
          wr_en      = 1'b1;
          rx_total_d = rx_total_q + CNT_W'(1);
          state_d    = ACK;
        end
      end
      ACK: begin
        if (bus.send == SEND_IDLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack      = (state_q == ACK) ? ACK_OK : ACK_IDLE;
  assign bus.rx_total = rx_total_q;
  assign bus.err      = err_q;

  rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (bus.dado),
    .rd_en_i   (bus.rd_en),
    .rd_data_o (bus.rd_data),
    .count_o   (bus.count),
    .empty_o   (bus.empty),
    .full_o    (bus.full)
  );
endmodule

// File: doc/fsm_receptor.md
# fsm_receptor

- Downstream consumer for one processor send/ack channel.
- Takes words from the processor FSM over its 2-bit `send` / 2-bit `ack` four-phase handshake and buffers them in a small FIFO.
- Exposes the buffered words on a simple read port.
- One instance sits on each channel (`send`/`ack` and `send2`/`ack2`); the instance's `ack` output feeds the processor's `ack` (or `ack2`) input.

## Interface

One clock; reset is asynchronous and active-high (`clk`, `rst`).

Parameters:
- `DATA_W`, 16: width of `dado` and stored words.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the received-word counter.

Ports:
- `clk`, in, 1: clock; all state changes on rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `send`, in, 2: request code from the processor; 2'b01 = word valid, 2'b00 = idle, 2'b10/2'b11 illegal.
- `dado`, in, DATA_W: data word, valid while `send`==2'b01.
- `ack`, out, 2: handshake response; 2'b01 = accepted, 2'b00 = idle; registered.
- `rd_en`, in, 1: pop one word from the FIFO.
- `rd_data`, out, DATA_W: last popped word; registered.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `empty`, out, 1: `count`==0.
- `full`, out, 1: `count`==DEPTH.
- `rx_total`, out, CNT_W: words accepted since reset; wraps modulo 2^CNT_W.
- `err`, out, 1: sticky flag, set when an illegal `send` code is sampled.

## Operation

Reset values:
- Outputs: `ack`=2'b00, `rd_data`=0, `count`=0, `empty`=1, `full`=0, `rx_total`=0, `err`=0.
- Internal: FSM in IDLE, FIFO pointers 0.
- Reset asserted mid-handshake drops `ack` immediately and discards all buffered words.

FSM states:
- IDLE (`ack`=00): if `send`==01 and `full`==0, write `dado` at the tail, increment `rx_total`, go to ACK. If `send`==01 and `full`==1, stay in IDLE; the word is not taken. Any other code: stay.
- ACK (`ack`=01): hold until `send`==00 is sampled, then go to IDLE. While `send`==01, no further write.

Illegal codes:
- `send`==10 or 11 in any state sets `err`=1 and causes no write.
- The state is unchanged; only `rst` clears `err`.

Read port:
- `rd_en`=1 with `empty`=0: head word moves to `rd_data` and the head pointer advances.
- `rd_en` with `empty`=1: ignored; `rd_data` holds.

FIFO rules:
- Pointers wrap modulo DEPTH.
- `count` updates: write only +1, read only −1, simultaneous write and read unchanged.
- Admission uses `full` as it was before the edge. A pop on the same edge does not allow a write while full; the write is taken on the following IDLE cycle.

## Timing

- `send`==01 sampled at edge k (IDLE, not full):
  - FIFO written at edge k.
  - `ack`=01, `count`+1 and `rx_total`+1 visible after edge k.
- `send`==00 sampled at edge m (ACK): `ack`=00 visible after edge m. The next word can be accepted at edge m+1 at the earliest.
- Minimum handshake period is 2 cycles per word when the sender responds combinationally.
- `rd_en` at edge j: `rd_data` and `count` update after edge j. A word written at edge k can be popped at edge k+1 at the earliest; no write-to-read bypass.
- `empty` and `full` derive combinationally from registered `count`.

## Structure

Shared package `receptor_pkg`:
- State enum `rx_state_t` {IDLE, ACK}.
- Constants `SEND_IDLE`=2'b00, `SEND_REQ`=2'b01, `ACK_IDLE`=2'b00, `ACK_OK`=2'b01.

Natural sub-module `rx_fifo`:
- Parameterised on DATA_W/DEPTH; owns storage, pointers, `count`, `empty`, `full` and registered `rd_data`.
- `fsm_receptor` instantiates it and keeps only the FSM, `rx_total` and `err`.

## Test plan

- Reset mid-handshake: `rst` pulses during ACK after 3 words were accepted → `ack`=00 within the same cycle, `count`=0, `empty`=1, `rx_total`=0, `err`=0.
- Single transfer: `send`=01, `dado`=16'h00A5 → `ack`=01 next cycle, `count`=1; `send`=00 → `ack`=00; `rd_en` → `rd_data`=16'h00A5, `empty`=1.
- Back-pressure: 4 words (16'h0001–16'h0004) accepted, 5th `send`=01 held → `ack` stays 00. `rd_en` pulse → `rd_data`=16'h0001, then 5th word accepted one cycle later, `count`=4.
- Wrap-around: 10 words pushed and popped interleaved → output order preserved (1..10), `rx_total`=10.
- Illegal code: `send`=2'b10 for one cycle in IDLE → `err`=1, `count` unchanged, `ack`=00. A subsequent valid transfer still completes and `err` stays 1.
- Simultaneous / empty read: write and `rd_en` on the same edge at `count`=2 → `count` stays 2. `rd_en` with `empty`=1 → `rd_data` unchanged.
